// File: rtl/alu_pkg.sv
// Shared definitions for the ALU BIST sequencer: opcodes, FSM states and the
// golden ALU function used to judge every sampled response.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } bist_state_t;

    // Returns {carry, zero, out}; carry is the borrow for SUB and 0 for logic ops.
    function automatic logic [ALU_W+1:0] alu_ref(
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b,
        input logic [2:0]       sel
    );
        logic [ALU_W:0] r;
        r = '0;
        case (sel)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_NOT:  r = {1'b0, ~a};
            OP_SHL:  r = {1'b0, a[ALU_W-2:0], 1'b0};
            OP_SHR:  r = {2'b00, a[ALU_W-1:1]};
            default: r = '0;
        endcase
        return {r[ALU_W], (r[ALU_W-1:0] == '0), r[ALU_W-1:0]};
    endfunction

endpackage

// File: rtl/alu_bist_seq_if.sv
// Bus between the BIST sequencer (master) and the ALU under test (slave).
interface alu_bist_seq_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             alu_zero;

    modport master (
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_carry, alu_zero
    );

    modport slave (
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_carry, alu_zero
    );
endinterface

// File: rtl/alu_golden.sv
// Combinational golden ALU; thin wrapper so the reference sits as one instance.
module alu_golden
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       sel,
    output logic [ALU_W-1:0] out,
    output logic             carry,
    output logic             zero
);
    assign {carry, zero, out} = alu_ref(a, b, sel);
endmodule

// File: rtl/alu_bist_seq.sv
// ALU BIST sequencer: walks vectors onto the ALU, waits SETTLE cycles, checks
// the response against the golden model and keeps error count / first failure.
//
// state   | meaning
// S_IDLE  | waiting for first start after reset
// S_DRIVE | current vector presented to the ALU
// S_WAIT  | settle window, SETTLE cycles
// S_CHECK | sample ALU response, compare, advance vector
// S_DONE  | results valid, last vector held; start reruns
module alu_bist_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_W,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exhaustive,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    alu_bist_seq_if.master   alu,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_sel
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int VW = 2 * WIDTH + 3;

    bist_state_t      state, state_nxt;
    logic             mode_ex;
    logic [WIDTH-1:0] vec_a, vec_b;
    logic [2:0]       vec_sel;
    logic [VW-1:0]    vec_inc;
    logic [SW-1:0]    settle_cnt;
    logic             accept, last_vec, mismatch;
    logic [WIDTH-1:0] gold_out;
    logic             gold_carry, gold_zero;

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign last_vec = (vec_sel == 3'd7) && (!mode_ex || (&vec_a && &vec_b));
    assign vec_inc  = {vec_a, vec_b, vec_sel} + VW'(1);

    alu_golden u_golden (
        .a     (vec_a),
        .b     (vec_b),
        .sel   (vec_sel),
        .out   (gold_out),
        .carry (gold_carry),
        .zero  (gold_zero)
    );

    assign mismatch = {alu.alu_carry, alu.alu_zero, alu.alu_out} !=
                      {gold_carry, gold_zero, gold_out};

    assign alu.alu_a   = vec_a;
    assign alu.alu_b   = vec_b;
    assign alu.alu_sel = vec_sel;
    assign pass        = done && (err_count == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_DRIVE;
            S_DRIVE: state_nxt = S_WAIT;
            S_WAIT:  if (settle_cnt == '0) state_nxt = S_CHECK;
            S_CHECK: state_nxt = last_vec ? S_DONE : S_DRIVE;
            S_DONE:  if (start) state_nxt = S_DRIVE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_ex    <= 1'b0;
            vec_a      <= '0;
            vec_b      <= '0;
            vec_sel    <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sel   <= '0;
        end else if (accept) begin
            mode_ex   <= exhaustive;
            vec_a     <= exhaustive ? '0 : seed_a;
            vec_b     <= exhaustive ? '0 : seed_b;
            vec_sel   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_sel  <= '0;
        end else begin
            case (state)
                S_DRIVE: settle_cnt <= SW'(SETTLE - 1);
                S_WAIT:  if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (err_count == 16'd0) begin
                            fail_a   <= vec_a;
                            fail_b   <= vec_b;
                            fail_sel <= vec_sel;
                        end
                    end
                    if (last_vec) begin
                        busy <= 1'b0;
                    end else if (mode_ex) begin
                        {vec_a, vec_b, vec_sel} <= vec_inc;
                    end else begin
                        vec_sel <= vec_sel + 3'd1;
                    end
                end
                // done rises one cycle after busy falls so results are settled first
                S_DONE:  done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_seq.sv
// Bench for alu_bist_seq: a fault-injectable behavioural ALU on the bus and a
// scoreboard of expected vectors checked as the sequencer presents them.
module tb_alu_bist_seq;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } vec_t;

    localparam int PER = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       exhaustive = 1'b0;
    logic [3:0] seed_a = '0;
    logic [3:0] seed_b = '0;
    logic       busy, done, pass;
    logic [15:0] err_count;
    logic [3:0] fail_a, fail_b;
    logic [2:0] fail_sel;

    int fault = 0;
    int total = 0;
    int bad = 0;

    vec_t exp_q[$];
    int   exp_err;
    vec_t exp_fail;
    vec_t last_v;

    alu_bist_seq_if #(.WIDTH(4)) bus ();

    alu_bist_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .exhaustive (exhaustive),
        .seed_a     (seed_a),
        .seed_b     (seed_b),
        .alu        (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_sel   (fail_sel)
    );

    always #5 clk = ~clk;

    // {carry, zero, out}; flt 1 = SUB carry stuck at 0, flt 2 = out[0] stuck at 1
    function automatic logic [5:0] bench_alu(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] sel, input int flt);
        logic [4:0] r;
        logic [3:0] o;
        logic       c;
        case (sel)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, ~a};
            3'd6:    r = {1'b0, a[2:0], 1'b0};
            default: r = {2'b00, a[3:1]};
        endcase
        o = r[3:0];
        c = r[4];
        if (flt == 1 && sel == 3'd1) c = 1'b0;
        if (flt == 2) o[0] = 1'b1;
        return {c, (o == 4'd0), o};
    endfunction

    assign {bus.alu_carry, bus.alu_zero, bus.alu_out} =
        bench_alu(bus.alu_a, bus.alu_b, bus.alu_sel, fault);

    // Builds the expected vector stream, runs one sequence and checks it on the fly.
    task automatic run_seq(input bit ex, input logic [3:0] sa, input logic [3:0] sb,
                           input int glitch_at, output int done_cycle);
        vec_t v, got, want;
        int   nvec, n, budget;
        bit   seen;
        exp_q.delete();
        exp_err  = 0;
        exp_fail = '0;
        for (int ia = 0; ia < (ex ? 16 : 1); ia++)
            for (int ib = 0; ib < (ex ? 16 : 1); ib++)
                for (int s = 0; s < 8; s++) begin
                    v.a   = ex ? ia[3:0] : sa;
                    v.b   = ex ? ib[3:0] : sb;
                    v.sel = s[2:0];
                    exp_q.push_back(v);
                    if (bench_alu(v.a, v.b, v.sel, fault) !== bench_alu(v.a, v.b, v.sel, 0)) begin
                        if (exp_err == 0) exp_fail = v;
                        exp_err++;
                    end
                end
        nvec   = exp_q.size();
        last_v = exp_q[$];
        budget = nvec * PER + 20;
        done_cycle = -1;

        exhaustive = ex;
        seed_a = sa;
        seed_b = sb;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n    = 0;
        seen = 0;
        while (n < budget && !seen) begin
            if (n == 0) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL accept_flags: busy=%b done=%b, required busy=1 done=0", busy, done);
                end
            end
            if (n % PER == 0 && n < nvec * PER) begin
                got = {bus.alu_a, bus.alu_b, bus.alu_sel};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL vector_underflow: got a=%0d b=%0d sel=%0d with nothing expected",
                             got.a, got.b, got.sel);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL vector_order at n=%0d: got a=%0d b=%0d sel=%0d, required a=%0d b=%0d sel=%0d",
                                 n, got.a, got.b, got.sel, want.a, want.b, want.sel);
                    end
                end
            end
            if (n == nvec * PER) begin
                total++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL end_flags: busy=%b done=%b, required busy=0 done=0", busy, done);
                end
            end
            if (done === 1'b1) begin
                seen = 1;
                done_cycle = n;
            end else begin
                start = (n == glitch_at);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: done not seen within %0d cycles", budget);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL vector_count: %0d expected vectors never presented", exp_q.size());
        end
        if (seen) begin
            repeat (2) @(negedge clk);
            got = {bus.alu_a, bus.alu_b, bus.alu_sel};
            total++;
            if (got !== last_v || done !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL done_hold: a=%0d b=%0d sel=%0d done=%b busy=%b, required a=%0d b=%0d sel=%0d done=1 busy=0",
                         got.a, got.b, got.sel, done, busy, last_v.a, last_v.b, last_v.sel);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, pass} !== 3'b000 || err_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_status: busy=%b done=%b pass=%b err=%0d, required all 0",
                     busy, done, pass, err_count);
        end
        total++;
        if ({fail_a, fail_b, fail_sel} !== 11'd0 || {bus.alu_a, bus.alu_b, bus.alu_sel} !== 11'd0) begin
            bad++;
            $display("FAIL reset_regs: fail=%h alu=%h, required 0 and 0",
                     {fail_a, fail_b, fail_sel}, {bus.alu_a, bus.alu_b, bus.alu_sel});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_results(input string name, input int dc, input int want_dc);
        total++;
        if (dc != want_dc) begin
            bad++;
            $display("FAIL %s_latency: done after %0d cycles, required %0d", name, dc, want_dc);
        end
        total++;
        if (err_count !== exp_err[15:0] || pass !== (exp_err == 0)) begin
            bad++;
            $display("FAIL %s_errors: err=%0d pass=%b, required err=%0d pass=%b",
                     name, err_count, pass, exp_err, (exp_err == 0));
        end
        total++;
        if ({fail_a, fail_b, fail_sel} !== exp_fail) begin
            bad++;
            $display("FAIL %s_first: a=%0d b=%0d sel=%0d, required a=%0d b=%0d sel=%0d",
                     name, fail_a, fail_b, fail_sel, exp_fail.a, exp_fail.b, exp_fail.sel);
        end
    endtask

    task automatic test_single_good;
        int dc;
        fault = 0;
        run_seq(1'b0, 4'd5, 4'd3, -1, dc);
        check_results("single_good", dc, 8 * PER + 1);
    endtask

    task automatic test_sub_carry_fault;
        int dc;
        fault = 1;
        run_seq(1'b0, 4'd3, 4'd5, -1, dc);
        check_results("sub_carry", dc, 8 * PER + 1);
        total++;
        if (err_count !== 16'd1 || fail_sel !== 3'b001 || fail_a !== 4'd3 || fail_b !== 4'd5) begin
            bad++;
            $display("FAIL sub_carry_fixed: err=%0d a=%0d b=%0d sel=%0d, required err=1 a=3 b=5 sel=1",
                     err_count, fail_a, fail_b, fail_sel);
        end
    endtask

    task automatic test_out0_fault;
        int dc;
        fault = 2;
        run_seq(1'b0, 4'd5, 4'd3, -1, dc);
        check_results("out0_stuck", dc, 8 * PER + 1);
        total++;
        if (fail_sel !== 3'b000 || pass !== 1'b0) begin
            bad++;
            $display("FAIL out0_first_sel: sel=%0d pass=%b, required sel=0 pass=0", fail_sel, pass);
        end
    endtask

    task automatic test_back_to_back;
        int dc;
        fault = 0;
        run_seq(1'b0, 4'd5, 4'd3, 7, dc);
        check_results("rerun_glitch", dc, 8 * PER + 1);
    endtask

    task automatic test_exhaustive;
        int dc;
        fault = 0;
        run_seq(1'b1, 4'd9, 4'd6, 100, dc);
        check_results("exhaustive", dc, 256 * 8 * PER + 1);
    endtask

    task automatic test_reset_midrun;
        int dc;
        fault = 2;
        exhaustive = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (400) @(negedge clk);
        total++;
        if (busy !== 1'b1 || err_count == 16'd0) begin
            bad++;
            $display("FAIL midrun_active: busy=%b err=%0d, required busy=1 err>0", busy, err_count);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, pass} !== 3'b000 || err_count !== 16'd0 ||
            {fail_a, fail_b, fail_sel} !== 11'd0 || {bus.alu_a, bus.alu_b, bus.alu_sel} !== 11'd0) begin
            bad++;
            $display("FAIL midrun_reset: busy=%b done=%b pass=%b err=%0d fail=%h alu=%h, required all 0",
                     busy, done, pass, err_count, {fail_a, fail_b, fail_sel},
                     {bus.alu_a, bus.alu_b, bus.alu_sel});
        end
        @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrun_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        run_seq(1'b1, 4'd0, 4'd0, -1, dc);
        check_results("midrun_rerun", dc, 256 * 8 * PER + 1);
    endtask

    initial begin
        test_reset();
        test_single_good();
        test_sub_carry_fault();
        test_out0_fault();
        test_back_to_back();
        test_exhaustive();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
